// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register for the RV32I core: resolves branches and jumps, issues PC
// redirects, and holds the MEM-stage control/data along with the forwarding source.
module ex_mem_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_W       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic [PC_W-1:0]       ex_pc,
  input  logic [DATA_WIDTH-1:0] ex_imm,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_mem_to_reg,
  input  logic                  ex_branch,
  input  logic                  ex_jal,
  input  logic                  ex_jalr,
  output logic                  mem_valid,
  output logic [DATA_WIDTH-1:0] mem_result,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  mem_reg_write,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  mem_mem_to_reg,
  output logic                  redirect,
  output logic [PC_W-1:0]       redirect_pc,
  output logic                  misalign,
  output logic                  fwd_we
);

  logic                  valid_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  reg_write_q;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic                  mem_to_reg_q;
  logic                  taken_q;
  logic [PC_W-1:0]       target_q;

  logic                  taken_d;
  logic [PC_W-1:0]       target_d;
  logic [PC_W-1:0]       link_pc;
  logic [DATA_WIDTH-1:0] result_d;
  logic                  squash;

  // Target selection and link value; the immediate is sign-extended into the PC width
  always_comb begin
    taken_d  = ex_valid & (ex_jal | ex_jalr | (ex_branch & alu_result[0]));
    link_pc  = ex_pc + PC_W'(4);
    target_d = ex_pc + PC_W'($signed(ex_imm));
    if (ex_jalr) begin
      target_d = PC_W'(alu_result) & ~PC_W'(1);
    end
    result_d = alu_result;
    if (ex_jal | ex_jalr) begin
      result_d = DATA_WIDTH'(link_pc);
    end
  end

  assign squash = redirect;

  // Stall holds everything; a redirect squashes the wrong-path instruction behind it
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      result_q     <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      taken_q      <= 1'b0;
      target_q     <= '0;
    end else if (stall) begin
      valid_q <= valid_q;
    end else if (flush | squash) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      taken_q      <= 1'b0;
    end else begin
      valid_q      <= ex_valid;
      result_q     <= result_d;
      wdata_q      <= ex_rs2;
      rd_q         <= ex_rd;
      reg_write_q  <= ex_valid & ex_reg_write & ~ex_branch;
      mem_read_q   <= ex_valid & ex_mem_read;
      mem_write_q  <= ex_valid & ex_mem_write;
      mem_to_reg_q <= ex_valid & ex_mem_to_reg;
      taken_q      <= taken_d;
      target_q     <= target_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_result     = result_q;
  assign mem_wdata      = wdata_q;
  assign mem_rd         = rd_q;
  assign mem_reg_write  = valid_q & reg_write_q & (rd_q != '0);
  assign mem_mem_read   = valid_q & mem_read_q;
  assign mem_mem_write  = valid_q & mem_write_q;
  assign mem_mem_to_reg = mem_to_reg_q;
  assign redirect       = valid_q & taken_q;
  assign redirect_pc    = target_q;
  assign misalign       = valid_q & taken_q & target_q[1];
  assign fwd_we         = mem_reg_write & ~mem_mem_read;

endmodule
